cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the multicycle ARM core.
- Consumes decoder outputs FlagW, PCS, NextPC, RegW and MemW, the instruction condition field Cond (Instr[31:28]) and the ALU NZCV flags.
- Holds the architectural NZCV flag register and evaluates all 16 ARM condition codes.
- Gates PC, register-file and memory write enables so that non-executing instructions have no architectural effect.

Parameters:
- FLAGS_RST, 4'b0000, reset value of the NZCV register as {N,Z,C,V}.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V} of the current cycle.
- FlagW  in  2  decoder flag-write request; [1] = N,Z, [0] = C,V.
- PCS  in  1  decoder: instruction writes PC (branch or Rd=R15 with RegW).
- NextPC  in  1  FSM: unconditional PC increment (fetch state).
- RegW  in  1  FSM register-file write request.
- MemW  in  1  FSM memory write request.
- PCWrite  out  1  gated PC write enable.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated memory write enable.
- Flags  out  4  current architectural {N,Z,C,V} register.
- CondExD  out  1  registered condition-pass bit, for debug/trace.

Behaviour:
- Reset (sampled at the rising edge with reset=1):
  - Flags <= FLAGS_RST; CondExD <= 0.
  - Reset overrides every other update in that cycle.
  - A reset asserted mid-instruction aborts it: writes that cycle still follow the combinational equations below, but the next cycle sees CondExD=0.
- Condition evaluation, combinational CondEx, uses the registered Flags (never ALUFlags) and Cond:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111: 0. The unconditional space is unsupported and treated as never-execute.
- Flag update:
  - FlagWrite[1] = FlagW[1] & CondEx; FlagWrite[0] = FlagW[0] & CondEx.
  - At a clock edge with FlagWrite[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - At a clock edge with FlagWrite[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent; either half may be written alone.
  - New flags become visible to CondEx one cycle later. An instruction never sees its own flag result.
- CondExD <= CondEx at every non-reset edge. This carries the decision from the decode cycle into the later execute/memory/writeback cycles of the multicycle FSM.
- Outputs are combinational, with no extra latency:
  - PCWrite = (PCS & CondExD) | NextPC
  - RegWrite = RegW & CondExD
  - MemWrite = MemW & CondExD
- NextPC always passes ungated. Fetch must advance even after a failed condition.
- During reset cycles, RegWrite=MemWrite=0 once CondExD is cleared, and PCWrite=NextPC.
- Simultaneous events:
  - A flag write and a CondEx evaluation in the same cycle use the old flags for CondEx.
  - X on Cond while CondExD is not consumed is permitted; the core guarantees Cond is stable from the decode state onward.

Test Plan:
- Reset: assert reset 2 cycles with FLAGS_RST=0 → Flags=0000, CondExD=0; NextPC=1,RegW=1,MemW=1 → PCWrite=1, RegWrite=0, MemWrite=0.
- Flag write AL: Cond=1110, FlagW=11, ALUFlags=0100, one edge → Flags=0100 next cycle; then Cond=0000 (EQ) → CondExD=1 after next edge, RegW=1 → RegWrite=1.
- Condition fail suppresses everything: Flags=0100, Cond=0001 (NE), FlagW=11, ALUFlags=1010, PCS=1, MemW=1 → Flags stays 0100, CondExD=0, PCWrite=0 (NextPC=0), MemWrite=0.
- Partial flag write: Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 → Flags=1100 (C,V unchanged); then FlagW=01, ALUFlags=0011 → Flags=1111.
- Sweep all 16 Cond codes against all 16 Flags values → CondExD matches the table exactly, including HI/LS with C=1,Z=1 → HI=0, LS=1, GE/LT with N=1,V=0 → GE=0, LT=1, and 1111 → 0.
- Same-cycle hazard: Flags=0000, Cond=0000 (EQ), FlagW=10, ALUFlags=0100 in one cycle → CondEx uses old Z=0, no flag write occurs, Flags remains 0000, CondExD=0.

Source files
------------

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder/FSM request and gated write-enable bundle for the conditional-execution stage.
interface cond_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondExD;
  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondExD
  );
  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondExD
  );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: holds NZCV, evaluates ARM condition codes and gates PC/register/memory write enables.
module cond_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);
  logic [3:0] flags;
  logic       cond_ex, cond_ex_d;
  logic       n, z, c, v;
  assign {n, z, c, v} = flags;
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c & !z;
      4'b1001: cond_ex = !c | z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = !z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // Condition is judged on the old flags, so an instruction never sees its own result.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= FLAGS_RST;
      cond_ex_d <= 1'b0;
    end else begin
      if (bus.FlagW[1] & cond_ex) flags[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0] & cond_ex) flags[1:0] <= bus.ALUFlags[1:0];
      cond_ex_d <= cond_ex;
    end
  end
  assign bus.Flags    = flags;
  assign bus.CondExD  = cond_ex_d;
  assign bus.PCWrite  = (bus.PCS & cond_ex_d) | bus.NextPC;
  assign bus.RegWrite = bus.RegW & cond_ex_d;
  assign bus.MemWrite = bus.MemW & cond_ex_d;
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and random checks of cond_unit against a behavioural model.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  cond_unit_if bus ();
  cond_unit #(.FLAGS_RST(4'b0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [3:0] mflags;
  logic       mcd;
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !cc || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_flags"}, bus.Flags, mflags);
    chk({tag, "_cexd"}, {3'b0, bus.CondExD}, {3'b0, mcd});
    chk({tag, "_pcw"}, {3'b0, bus.PCWrite}, {3'b0, (bus.PCS & mcd) | bus.NextPC});
    chk({tag, "_regw"}, {3'b0, bus.RegWrite}, {3'b0, bus.RegW & mcd});
    chk({tag, "_memw"}, {3'b0, bus.MemWrite}, {3'b0, bus.MemW & mcd});
  endtask
  task automatic drive(input logic [3:0] cnd, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic npc, input logic rw, input logic mw, input logic rst);
    bus.Cond = cnd; bus.ALUFlags = alu; bus.FlagW = fw;
    bus.PCS = pcs; bus.NextPC = npc; bus.RegW = rw; bus.MemW = mw; reset = rst;
  endtask
  task automatic step(input string tag);
    logic ce, r;
    logic [1:0] fw;
    logic [3:0] alu;
    ce = cond_ok(bus.Cond, mflags);
    r = reset; fw = bus.FlagW; alu = bus.ALUFlags;
    @(posedge clk);
    if (r) begin
      mflags = 4'b0000;
      mcd = 1'b0;
    end else begin
      if (fw[1] && ce) mflags[3:2] = alu[3:2];
      if (fw[0] && ce) mflags[1:0] = alu[1:0];
      mcd = ce;
    end
    #1 check_all(tag);
  endtask
  initial begin
    mflags = 4'b0000;
    mcd = 1'b0;
    drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    step("rst1");
    step("rst2");
    chk("rst_flags", bus.Flags, 4'b0000);
    chk("rst_pcw", {3'b0, bus.PCWrite}, 4'd1);
    chk("rst_regw", {3'b0, bus.RegWrite}, 4'd0);
    chk("rst_memw", {3'b0, bus.MemWrite}, 4'd0);
    drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("al_fw");
    chk("al_flags", bus.Flags, 4'b0100);
    drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("eq_pass");
    chk("eq_regw", {3'b0, bus.RegWrite}, 4'd1);
    drive(4'b0001, 4'b1010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ne_fail");
    chk("ne_flags", bus.Flags, 4'b0100);
    chk("ne_pcw", {3'b0, bus.PCWrite}, 4'd0);
    chk("ne_memw", {3'b0, bus.MemWrite}, 4'd0);
    drive(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("clr");
    drive(4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("part_hi");
    chk("part_hi_flags", bus.Flags, 4'b1100);
    drive(4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("part_lo");
    chk("part_lo_flags", bus.Flags, 4'b1111);
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sweep_set");
        drive(4'(c), 4'(~f), 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("sweep");
        if (f == 4'b0110 && c == 8)  chk("hi_cz", {3'b0, bus.CondExD}, 4'd0);
        if (f == 4'b0110 && c == 9)  chk("ls_cz", {3'b0, bus.CondExD}, 4'd1);
        if (f == 4'b1000 && c == 10) chk("ge_nv", {3'b0, bus.CondExD}, 4'd0);
        if (f == 4'b1000 && c == 11) chk("lt_nv", {3'b0, bus.CondExD}, 4'd1);
        if (c == 15)                 chk("nv_never", {3'b0, bus.CondExD}, 4'd0);
      end
    end
    drive(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hz_clr");
    drive(4'b0000, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hazard");
    chk("hz_flags", bus.Flags, 4'b0000);
    chk("hz_cexd", {3'b0, bus.CondExD}, 4'd0);
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
      step("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
